// File: rtl/vend_mode_ctrl_if.sv
// Handshake/data bundle between the vending sequencer and its customer/owner side.
// The slave modport is the sequencer view; master is the driver of coins, selections and owner requests.
interface vend_mode_ctrl_if;
  logic       coin_in;
  logic [2:0] coin_val;
  logic       sel_req;
  logic [4:0] sel_price;
  logic       cancel;
  logic       own_req;
  logic [1:0] mode;
  logic [4:0] credit;
  logic [4:0] machine_acc;
  logic       coin_rej;
  logic       vend_ok;
  logic       vend_fail;
  logic       refund;
  logic [4:0] refund_amt;
  logic       own_grant;

  modport master (
    output coin_in, coin_val, sel_req, sel_price, cancel, own_req,
    input  mode, credit, machine_acc, coin_rej, vend_ok, vend_fail,
           refund, refund_amt, own_grant
  );

  modport slave (
    input  coin_in, coin_val, sel_req, sel_price, cancel, own_req,
    output mode, credit, machine_acc, coin_rej, vend_ok, vend_fail,
           refund, refund_amt, own_grant
  );
endinterface

// File: rtl/vend_mode_ctrl.sv
// Vending sequencer: customer credit/vend/refund vs owner retrieval; every output registered,
// one-cycle request-to-output latency, no backpressure (unusable coins are returned via coin_rej).
module vend_mode_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  vend_mode_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CREDIT   = 2'b01,
    VEND     = 2'b10,
    RETRIEVE = 2'b11
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic [4:0] acc_q, acc_d;
  logic [4:0] amt_q, amt_d;
  logic [4:0] price_q, price_d;
  logic [7:0] cnt_q, cnt_d;
  logic       coin_rej_q, coin_rej_d;
  logic       vend_ok_q, vend_ok_d;
  logic       vend_fail_q, vend_fail_d;
  logic       refund_q, refund_d;
  logic       grant_q, grant_d;

  // Six-bit sums so the overflow compares cannot wrap.
  logic [5:0] coin_sum;
  logic [5:0] acc_sum;
  assign coin_sum = {1'b0, credit_q} + {3'b000, bus.coin_val};
  assign acc_sum  = {1'b0, acc_q} + {1'b0, bus.sel_price};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      acc_q       <= '0;
      amt_q       <= '0;
      price_q     <= '0;
      cnt_q       <= '0;
      coin_rej_q  <= 1'b0;
      vend_ok_q   <= 1'b0;
      vend_fail_q <= 1'b0;
      refund_q    <= 1'b0;
      grant_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      acc_q       <= acc_d;
      amt_q       <= amt_d;
      price_q     <= price_d;
      cnt_q       <= cnt_d;
      coin_rej_q  <= coin_rej_d;
      vend_ok_q   <= vend_ok_d;
      vend_fail_q <= vend_fail_d;
      refund_q    <= refund_d;
      grant_q     <= grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    acc_d       = acc_q;
    amt_d       = amt_q;
    price_d     = price_q;
    cnt_d       = cnt_q;
    coin_rej_d  = 1'b0;
    vend_ok_d   = 1'b0;
    vend_fail_d = 1'b0;
    refund_d    = 1'b0;
    grant_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.own_req) begin
          state_d    = RETRIEVE;
          grant_d    = 1'b1;
          coin_rej_d = bus.coin_in;
        end else if (bus.coin_in) begin
          if (bus.coin_val != 3'd0) begin
            credit_d = {2'b00, bus.coin_val};
            cnt_d    = '0;
            state_d  = CREDIT;
          end else begin
            coin_rej_d = 1'b1;
          end
        end
      end

      CREDIT: begin
        // An expired idle counter is handled exactly like a customer cancel.
        if (bus.cancel || cnt_q == TO_LIMIT) begin
          refund_d   = 1'b1;
          amt_d      = credit_q;
          credit_d   = '0;
          cnt_d      = '0;
          coin_rej_d = bus.coin_in;
          state_d    = IDLE;
        end else if (bus.sel_req) begin
          cnt_d      = '0;
          coin_rej_d = bus.coin_in;
          if (credit_q >= bus.sel_price && acc_sum <= 6'd31) begin
            state_d   = VEND;
            price_d   = bus.sel_price;
            vend_ok_d = 1'b1;
            if (credit_q != bus.sel_price) begin
              refund_d = 1'b1;
              amt_d    = credit_q - bus.sel_price;
            end
          end else begin
            vend_fail_d = 1'b1;
          end
        end else if (bus.coin_in && bus.coin_val != 3'd0 && coin_sum <= 6'd31) begin
          credit_d = coin_sum[4:0];
          cnt_d    = '0;
        end else begin
          coin_rej_d = bus.coin_in;
          cnt_d      = cnt_q + 8'd1;
        end
      end

      VEND: begin
        acc_d      = acc_q + price_q;
        credit_d   = '0;
        coin_rej_d = bus.coin_in;
        state_d    = IDLE;
      end

      RETRIEVE: begin
        acc_d      = '0;
        coin_rej_d = bus.coin_in;
        state_d    = IDLE;
      end
    endcase
  end

  assign bus.mode        = state_q;
  assign bus.credit      = credit_q;
  assign bus.machine_acc = acc_q;
  assign bus.coin_rej    = coin_rej_q;
  assign bus.vend_ok     = vend_ok_q;
  assign bus.vend_fail   = vend_fail_q;
  assign bus.refund      = refund_q;
  assign bus.refund_amt  = amt_q;
  assign bus.own_grant   = grant_q;

endmodule
